fetch: RTL
==========

// Module: fetch
// PURPOSE
//  - Instruction fetch stage of the in-order RV32I pipeline; the producer side of the decode stage's pc_i/inst interface.
//  - Holds the fetch PC and issues in-order requests to instruction memory.
//  - Buffers returned words with their PCs in a small queue and presents them to decode with a valid/ready handshake.
//  - Consumes decode's pcsel/branch_tar redirect: flushes wrong-path work and restarts fetch at the target.
// PARAMETERS
//  WIDTH     32          instruction/data width
//  ADDR_LEN  32          PC / memory address width
//  RESET_PC  32'h0       first fetch address after reset
//  QDEPTH    2           instruction queue entries; also the credit limit on (outstanding + queued)
// PORTS
//  clk             in   1         clock, rising edge
//  reset           in   1         asynchronous, active-high reset
//  imem_req_valid  out  1         fetch request valid
//  imem_req_ready  in   1         memory accepts request
//  imem_req_addr   out  ADDR_LEN  word-aligned fetch address
//  imem_rsp_valid  in   1         response valid; in order, >=1 cycle after its request handshake
//  imem_rsp_data   in   WIDTH     instruction word
//  inst_valid      out  1         queue head valid toward decode
//  decode_ready    in   1         decode consumes head this cycle
//  pc_o            out  ADDR_LEN  PC of head (decode pc_i)
//  inst_o          out  WIDTH     head instruction (decode inst); 32'h00000013 (NOP) when inst_valid=0
//  pcsel           in   2         from decode; 2'b00 = sequential, any nonzero value = redirect
//  branch_tar      in   ADDR_LEN  redirect target; bits [1:0] ignored (treated as 0)
// BEHAVIOUR
//  - Reset (async): fetch_pc = rsp_pc = RESET_PC; queue empty; outstanding = 0; drop_cnt = 0.
//    Reset outputs: imem_req_valid=0, imem_req_addr=RESET_PC, inst_valid=0, pc_o=0, inst_o=NOP.
//    Reset mid-flight drops all state; late responses are the memory model's responsibility.
//  - Credit rule: imem_req_valid = !redirect && (outstanding + count < QDEPTH). Handshake: fetch_pc += 4, outstanding++.
//  - imem_req_addr = fetch_pc; it is held stable while imem_req_valid=1 and imem_req_ready=0.
//  - Response handling:
//    - drop_cnt > 0: discard the word; drop_cnt--, outstanding--.
//    - drop_cnt = 0: push {rsp_pc, data}; rsp_pc += 4; outstanding--. The credit rule guarantees no overflow.
//  - Head = queue[rd_ptr], combinational to pc_o/inst_o. Pop on inst_valid && decode_ready. Push/pop can occur in the same cycle.
//  - Latency: response at cycle N makes the entry visible (inst_valid=1) at N+1. There is no bypass.
//  - Steady state (1-cycle memory, decode_ready=1): one instruction per cycle.
//  - Redirect cycle (pcsel != 0):
//    - The head handshake still completes; this is the branch/jump itself.
//    - All other queue entries are flushed.
//    - No request is issued.
//    - drop_cnt <= outstanding - imem_rsp_valid; a response arriving this cycle is discarded.
//    - fetch_pc <= rsp_pc <= {branch_tar[ADDR_LEN-1:2], 2'b00}.
//    - The first target request is issued the next cycle.
//  - Pointer wrap: rd_ptr/wr_ptr wrap modulo QDEPTH. count ranges over 0..QDEPTH.
//  - PC arithmetic wraps modulo 2^ADDR_LEN.
// CONFIGURATION
//  FETCH_PERF_EN defined:
//    - adds outputs perf_fetched[31:0] (pops) and perf_redirects[31:0] (redirect cycles) plus perf_dropped[31:0] (discarded responses).
//    - All three reset to 0 and wrap at 2^32.
//  FETCH_PERF_EN undefined: ports and counters are absent; all other behaviour is identical.
// TESTING
//  1. RESET_PC=0, 1-cycle memory, ready=1, decode_ready=1:
//     - requests 0x0, 0x4, 0x8...; pc_o 0x0, 0x4, 0x8 on consecutive cycles after fill.
//  2. decode_ready=0 for 6 cycles:
//     - count reaches 2, imem_req_valid=0; resume yields pc_o 0x0, 0x4, 0x8 with no skip or duplicate.
//  3. Two requests outstanding (0x8, 0xC), pcsel=2'b01, branch_tar=0x100:
//     - both responses dropped; next imem_req_addr=0x100; next inst_valid shows pc_o=0x100.
//  4. Redirect in the same cycle as a response with 1 outstanding:
//     - response discarded, drop_cnt=0 afterwards; first target word not dropped.
//  5. imem_req_ready=0 for 4 cycles:
//     - imem_req_addr stable, imem_req_valid held 1, no PC advance.
//  6. branch_tar=0x103; with FETCH_PERF_EN defined:
//     - fetch resumes at 0x100; perf_redirects=1; perf_dropped equals discarded count.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response plus the head-of-queue
// handshake and redirect from decode. The master modport is the fetch stage.
interface fetch_if #(
    parameter int WIDTH    = 32,
    parameter int ADDR_LEN = 32
);
    logic                imem_req_valid;
    logic                imem_req_ready;
    logic [ADDR_LEN-1:0] imem_req_addr;
    logic                imem_rsp_valid;
    logic [WIDTH-1:0]    imem_rsp_data;
    logic                inst_valid;
    logic                decode_ready;
    logic [ADDR_LEN-1:0] pc_o;
    logic [WIDTH-1:0]    inst_o;
    logic [1:0]          pcsel;
    logic [ADDR_LEN-1:0] branch_tar;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, pc_o, inst_o,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, decode_ready, pcsel, branch_tar
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, pc_o, inst_o,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, decode_ready, pcsel, branch_tar
    );
endinterface

// File: rtl/fetch.sv
// RV32I fetch stage: in-order imem requests, QDEPTH-entry instruction queue toward decode, redirect flush.
// Latency: a response in cycle N is visible at the queue head in cycle N+1 (no bypass).
// Backpressure: requests are credit-limited to (outstanding + queued) < QDEPTH; FETCH_PERF_EN adds perf counters.
module fetch #(
    parameter int                  WIDTH    = 32,
    parameter int                  ADDR_LEN = 32,
    parameter logic [ADDR_LEN-1:0] RESET_PC = '0,
    parameter int                  QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    fetch_if.master     bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_redirects,
    output logic [31:0] perf_dropped
`endif
);
    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = $clog2(QDEPTH + 1);
    localparam logic [WIDTH-1:0] NOP = WIDTH'(32'h0000_0013);

    typedef struct packed {
        logic [ADDR_LEN-1:0] pc;
        logic [WIDTH-1:0]    inst;
    } entry_t;

    entry_t              q_mem [QDEPTH];
    logic [ADDR_LEN-1:0] fetch_pc, rsp_pc, tgt_pc;
    logic [PTR_W-1:0]    rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
    logic [CNT_W-1:0]    count, count_nxt;
    logic [CNT_W-1:0]    outstanding, outstanding_nxt;
    logic [CNT_W-1:0]    drop_cnt, drop_cnt_nxt;
    logic                redirect, credit_ok, req_fire, pop, push, drop, keep_head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign redirect  = (bus.pcsel != 2'b00);
    assign tgt_pc    = {bus.branch_tar[ADDR_LEN-1:2], 2'b00};
    assign credit_ok = ({1'b0, outstanding} + {1'b0, count}) < (CNT_W + 1)'(QDEPTH);

    assign bus.imem_req_valid = !reset && !redirect && credit_ok;
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.inst_valid     = (count != '0);
    assign bus.pc_o           = bus.inst_valid ? q_mem[rd_ptr].pc   : '0;
    assign bus.inst_o         = bus.inst_valid ? q_mem[rd_ptr].inst : NOP;

    assign req_fire  = bus.imem_req_valid && bus.imem_req_ready;
    assign pop       = bus.inst_valid && bus.decode_ready;
    // A response landing in a redirect cycle belongs to the wrong path.
    assign drop      = bus.imem_rsp_valid && (redirect || drop_cnt != '0);
    assign push      = bus.imem_rsp_valid && !drop;
    assign keep_head = (count != '0) && !pop;

    always_comb begin
        rd_ptr_nxt      = pop ? ptr_inc(rd_ptr) : rd_ptr;
        wr_ptr_nxt      = push ? ptr_inc(wr_ptr) : wr_ptr;
        count_nxt       = count + CNT_W'(push) - CNT_W'(pop);
        drop_cnt_nxt    = (bus.imem_rsp_valid && drop_cnt != '0) ? drop_cnt - CNT_W'(1) : drop_cnt;
        outstanding_nxt = outstanding + CNT_W'(req_fire) - CNT_W'(bus.imem_rsp_valid);
        if (redirect) begin
            // The head (the branch itself) survives only if decode did not take it this cycle.
            count_nxt    = keep_head ? CNT_W'(1) : '0;
            wr_ptr_nxt   = keep_head ? ptr_inc(rd_ptr) : rd_ptr_nxt;
            drop_cnt_nxt = outstanding - CNT_W'(bus.imem_rsp_valid);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            rd_ptr      <= rd_ptr_nxt;
            wr_ptr      <= wr_ptr_nxt;
            count       <= count_nxt;
            outstanding <= outstanding_nxt;
            drop_cnt    <= drop_cnt_nxt;
            if (redirect) begin
                fetch_pc <= tgt_pc;
                rsp_pc   <= tgt_pc;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + ADDR_LEN'(4);
                if (push)     rsp_pc   <= rsp_pc + ADDR_LEN'(4);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) q_mem[wr_ptr] <= '{pc: rsp_pc, inst: bus.imem_rsp_data};
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched   <= '0;
            perf_redirects <= '0;
            perf_dropped   <= '0;
        end else begin
            perf_fetched   <= perf_fetched + 32'(pop);
            perf_redirects <= perf_redirects + 32'(redirect);
            perf_dropped   <= perf_dropped + 32'(drop);
        end
    end
`endif
endmodule
